// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the AXI slave async FIFO: write pointers, read-pointer sync, full/level/overflow.
// Optional almost-full flag built only when AFIFO_WR_ALMOST_FULL_EN is defined.
module afifo_wr_ctrl #(
   parameter int unsigned PTR_WIDTH  = 3,
   parameter int unsigned DATA_WIDTH = 39,
   parameter int unsigned AF_THRESH  = 6
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_full,
   output logic                  push_afull,
   output logic [PTR_WIDTH:0]    wr_level,
   output logic                  overflow,
   input  logic [PTR_WIDTH:0]    rgray_ptr_in,
   output logic [PTR_WIDTH:0]    wgray_ptr_out,
   output logic [PTR_WIDTH-1:0]  waddr,
   output logic                  wen,
   output logic [DATA_WIDTH-1:0] wdata
);

   logic [PTR_WIDTH:0] wbin_q, wbin_d;
   logic [PTR_WIDTH:0] wgray_q, wgray_d;
   logic [PTR_WIDTH:0] rq1_q, rq2_q;
   logic [PTR_WIDTH:0] rbin_s;
   logic [PTR_WIDTH:0] level_q, level_d;
   logic               full_q, full_d;
   logic               ovf_q, ovf_d;
   logic               accept;

   if ((PTR_WIDTH < 2) || (AF_THRESH < 1) || (AF_THRESH > (2 ** PTR_WIDTH))) begin : g_param_range_err
      $error("afifo_wr_ctrl: PTR_WIDTH must be >= 2 and AF_THRESH within 1..2**PTR_WIDTH");
   end

   always_comb begin
      // wen is forced low while reset is held, independent of push_full
      accept  = push & ~full_q & wrst_n;
      wbin_d  = wbin_q + {{PTR_WIDTH{1'b0}}, accept};
      wgray_d = wbin_d ^ (wbin_d >> 1);
      rbin_s  = '0;
      for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
         rbin_s[i] = ^(rq2_q >> i);
      end
      full_d  = (wgray_d == {~rq2_q[PTR_WIDTH -: 2], rq2_q[PTR_WIDTH-2:0]});
      level_d = wbin_d - rbin_s;
      ovf_d   = push & full_q;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         rq1_q   <= '0;
         rq2_q   <= '0;
         full_q  <= 1'b0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         rq1_q   <= rgray_ptr_in;
         rq2_q   <= rq1_q;
         full_q  <= full_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef AFIFO_WR_ALMOST_FULL_EN
   localparam logic [PTR_WIDTH:0] AF_THRESH_L = AF_THRESH[PTR_WIDTH:0];
   logic afull_q;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         afull_q <= 1'b0;
      end else begin
         afull_q <= (level_d >= AF_THRESH_L);
      end
   end

   assign push_afull = afull_q;
`else
   assign push_afull = 1'b0;
`endif

   assign push_full     = full_q;
   assign wr_level      = level_q;
   assign overflow      = ovf_q;
   assign wgray_ptr_out = wgray_q;
   assign wen           = accept;
   assign waddr         = wbin_q[PTR_WIDTH-1:0];
   assign wdata         = push_data;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Self-checking bench for afifo_wr_ctrl: occupancy model built from push/read counts and a 2-cycle visibility delay.
module tb_afifo_wr_ctrl;

   logic        wclk;
   logic        wrst_n;
   logic        push;
   logic [38:0] push_data;
   logic        push_full;
   logic        push_afull;
   logic [3:0]  wr_level;
   logic        overflow;
   logic [3:0]  rgray_ptr_in;
   logic [3:0]  wgray_ptr_out;
   logic [2:0]  waddr;
   logic        wen;
   logic [38:0] wdata;

   afifo_wr_ctrl #(
      .PTR_WIDTH (3),
      .DATA_WIDTH(39),
      .AF_THRESH (6)
   ) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .push         (push),
      .push_data    (push_data),
      .push_full    (push_full),
      .push_afull   (push_afull),
      .wr_level     (wr_level),
      .overflow     (overflow),
      .rgray_ptr_in (rgray_ptr_in),
      .wgray_ptr_out(wgray_ptr_out),
      .waddr        (waddr),
      .wen          (wen),
      .wdata        (wdata)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   int unsigned n_chk;
   int unsigned n_fail;

   // Reference state: total entries written, total entries read, read totals seen 1 and 2 edges ago.
   int   wcnt, rcnt, rs1, rs2, m_level;
   bit   m_full, m_ovf, m_afull;
   logic [3:0] prev_gray;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = 4'(v % 16);
      return b ^ (b >> 1);
   endfunction

   task automatic check_outs();
      check("push_full", 64'(push_full), 64'(m_full));
      check("wr_level", 64'(wr_level), 64'(m_level));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("push_afull", 64'(push_afull), 64'(m_afull));
      check("wgray", 64'(wgray_ptr_out), 64'(gray4(wcnt)));
      check("gray_step", 64'($countones(wgray_ptr_out ^ prev_gray) <= 1), 64'(1));
      prev_gray = wgray_ptr_out;
   endtask

   // Called just after a rising edge; applies inputs, checks the storage port, clocks, checks registers.
   task automatic cycle(input bit p, input logic [38:0] d, input bit rd);
      bit acc;
      if (rd && (rcnt < wcnt)) begin
         rcnt++;
         rgray_ptr_in = gray4(rcnt);
      end
      push      = p;
      push_data = d;
      #1;
      acc = p && !m_full;
      check("wen", 64'(wen), 64'(acc));
      if (acc) begin
         check("waddr", 64'(waddr), 64'(wcnt % 8));
         check("wdata", 64'(wdata), 64'(d));
      end
      @(posedge wclk);
      m_ovf = p && m_full;
      if (acc) wcnt++;
      m_level = wcnt - rs2;
      rs2     = rs1;
      rs1     = rcnt;
      m_full  = (m_level == 8);
`ifdef AFIFO_WR_ALMOST_FULL_EN
      m_afull = (m_level >= 6);
`else
      m_afull = 1'b0;
`endif
      #1;
      check_outs();
   endtask

   // Asserts reset away from any clock edge, checks everything clears at once, then releases.
   task automatic do_reset();
      wrst_n = 1'b0;
      push   = 1'b1;
      #1;
      check("rst_wen", 64'(wen), 64'(0));
      check("rst_full", 64'(push_full), 64'(0));
      check("rst_afull", 64'(push_afull), 64'(0));
      check("rst_level", 64'(wr_level), 64'(0));
      check("rst_ovf", 64'(overflow), 64'(0));
      check("rst_wgray", 64'(wgray_ptr_out), 64'(0));
      check("rst_waddr", 64'(waddr), 64'(0));
      wcnt = 0; rcnt = 0; rs1 = 0; rs2 = 0; m_level = 0;
      m_full = 1'b0; m_ovf = 1'b0; m_afull = 1'b0;
      prev_gray    = '0;
      rgray_ptr_in = '0;
      push         = 1'b0;
      @(posedge wclk);
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   initial begin
      logic [63:0] r64;
      n_chk        = 0;
      n_fail       = 0;
      wrst_n       = 1'b1;
      push         = 1'b0;
      push_data    = '0;
      rgray_ptr_in = '0;
      #2;
      do_reset();

      // Fill with read pointer held at zero
      for (int i = 0; i < 8; i++) cycle(1'b1, 39'(i), 1'b0);
      check("fill_full", 64'(push_full), 64'(1));
      check("fill_level", 64'(wr_level), 64'(8));
      check("fill_wgray", 64'(wgray_ptr_out), 64'(4'b1100));

      // Push while full is dropped and flagged for one cycle
      cycle(1'b1, 39'h55, 1'b0);
      check("ovf_pulse", 64'(overflow), 64'(1));
      check("ovf_level", 64'(wr_level), 64'(8));
      cycle(1'b0, '0, 1'b0);
      check("ovf_clear", 64'(overflow), 64'(0));

      // One read releases full only on the third edge
      cycle(1'b0, '0, 1'b1);
      check("rel_e1_full", 64'(push_full), 64'(1));
      cycle(1'b0, '0, 1'b0);
      check("rel_e2_full", 64'(push_full), 64'(1));
      cycle(1'b0, '0, 1'b0);
      check("rel_e3_full", 64'(push_full), 64'(0));
      check("rel_e3_level", 64'(wr_level), 64'(7));
      cycle(1'b1, 39'h1234, 1'b0);

      // Wrap-around with interleaved reads
      for (int i = 0; i < 20; i++) cycle(1'b1, 39'(100 + i), (i % 2) == 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r64 = {$urandom, $urandom};
         cycle($urandom_range(0, 3) != 0, r64[38:0], ($urandom % 2) == 1);
      end

      // Almost-full threshold: set after the 6th push, clear after the 5th
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 39'(i), 1'b0);
`ifdef AFIFO_WR_ALMOST_FULL_EN
         check("afull_thr", 64'(push_afull), 64'(i == 5));
`else
         check("afull_off", 64'(push_afull), 64'(0));
`endif
      end

      // Reset in the middle of a fill, then the next push restarts at address 0
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 39'(i), 1'b0);
      #2;
      do_reset();
      push = 1'b1;
      #1;
      check("post_rst_waddr", 64'(waddr), 64'(0));
      check("post_rst_wen", 64'(wen), 64'(1));
      cycle(1'b1, 39'h7f, 1'b0);
      cycle(1'b0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
